// File: rtl/result_fifo_if.sv
// Handshake bundle between a result producer/consumer pair and result_fifo.
// The FIFO attaches as the slave; the producer/consumer side uses the master modport.
interface result_fifo_if #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;

  modport master (
    output flush, wr_req, wr_data, out_ready,
    input  out_valid, out_data, full, empty, count, overflow
  );

  modport slave (
    input  flush, wr_req, wr_data, out_ready,
    output out_valid, out_data, full, empty, count, overflow
  );
endinterface

// File: rtl/result_fifo.sv
// First-word fall-through result FIFO: circular buffer with registered count,
// sticky overflow flag for dropped writes, synchronous flush and async reset.
module result_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  result_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  // A pop frees the slot in the same edge, so a full FIFO still accepts a write then.
  assign w_pop  = !w_empty && bus.out_ready;
  assign w_push = bus.wr_req && (!w_full || w_pop) && !bus.flush;
  assign w_drop = bus.wr_req && w_full && !w_pop && !bus.flush;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.out_valid = !w_empty;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  // Gating to zero makes out_data follow the async reset without a clock edge.
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
endmodule

// File: doc/result_fifo.md
RESULT_FIFO -- requirements
Module: result_fifo

Interface
REQ-001 SHALL have parameter: WIDTH, 21, result word width (matches wr_data).
REQ-002 SHALL have parameter: DEPTH, 8, number of storage entries (power of two, >= 2).
REQ-003 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: flush  input  1  synchronous clear of contents; does not clear overflow.
REQ-006 SHALL have port: wr_req  input  1  producer write strobe, one word per cycle high.
REQ-007 SHALL have port: wr_data  input  WIDTH  result word written when wr_req is accepted.
REQ-008 SHALL have port: out_ready  input  1  consumer can take the head word this cycle.
REQ-009 SHALL have port: out_valid  output  1  head word present (equals not empty).
REQ-010 SHALL have port: out_data  output  WIDTH  head word (first-word fall-through); zero when empty.
REQ-011 SHALL have port: full  output  1  count equals DEPTH.
REQ-012 SHALL have port: empty  output  1  count equals 0.
REQ-013 SHALL have port: count  output  log2(DEPTH)+1  number of stored words.
REQ-014 SHALL have port: overflow  output  1  sticky: a write was dropped since reset.

Function
REQ-015 SHALL store words in a circular buffer with write pointer, read pointer (log2(DEPTH) bits each, wrapping DEPTH-1 -> 0) and a registered count.
REQ-016 SHALL define pop = out_valid AND out_ready; pop removes the head word and advances the read pointer at the clock edge.
REQ-017 SHALL define push = wr_req AND (NOT full OR pop); push stores wr_data at the write pointer and advances it at the clock edge.
REQ-018 SHALL update count: push only +1, pop only -1, both or neither unchanged.
REQ-019 SHALL, on wr_req while full with no pop, drop the word, leave all pointers/contents unchanged, and set overflow to 1 at that edge.
REQ-020 SHALL hold overflow at 1 until reset; flush does not clear it.
REQ-021 SHALL make a word written into an empty FIFO visible on out_data/out_valid exactly one cycle after the push edge (latency 1); no same-cycle bypass.
REQ-022 SHALL, with empty and simultaneous wr_req and out_ready, perform push only (pop impossible while out_valid=0).
REQ-023 SHALL, with full and simultaneous wr_req and pop, accept both; count stays DEPTH, no overflow.
REQ-024 SHALL preserve strict FIFO order across pointer wrap-around.
REQ-025 SHALL, when flush=1, set pointers and count to 0 at the edge, ignoring same-cycle wr_req and out_ready; stored data values need not be cleared.
REQ-026 SHALL derive full, empty, out_valid combinationally from count; out_data from the storage at the read pointer gated to 0 when empty.
REQ-027 SHALL keep out_data stable while out_valid=1 and out_ready=0 (hold until pop).

Reset
REQ-028 SHALL, on reset=1, immediately (asynchronously) force pointers=0, count=0, overflow=0, hence empty=1, full=0, out_valid=0, out_data=0.
REQ-029 SHALL, on reset asserted mid-operation, discard all stored words; first word written after release appears at out_data one cycle after its push edge.
REQ-030 SHALL ignore wr_req, out_ready and flush while reset=1.

Verification
REQ-031 SHALL verify: reset, write 0x00001 then 0x1FFFFF with out_ready=0 -> count=2, out_data=0x00001; raise out_ready 2 cycles -> 0x00001 then 0x1FFFFF popped, empty=1.
REQ-032 SHALL verify: write 8 words 1..8, out_ready=0 -> full=1, count=8; 9th write of 9 -> overflow=1, count=8; drain yields 1..8 exactly.
REQ-033 SHALL verify: full FIFO, wr_req=1 data=0x55 with out_ready=1 -> head popped, 0x55 stored, count=8, overflow=0; wrap-around order preserved over 20 continuous push/pop cycles.
REQ-034 SHALL verify: empty FIFO, wr_req=1 data=0xABCDE with out_ready=1 -> same cycle out_valid=0; next cycle out_valid=1, out_data=0xABCDE.
REQ-035 SHALL verify: 5 words stored, overflow=1, flush=1 one cycle with wr_req=1 -> count=0, empty=1, overflow stays 1; then reset pulse mid-stream -> overflow=0, out_data=0 without waiting for a clock edge.
